// File: rtl/wbs_rgb_pwm_if.sv
// wbs_rgb_pwm_if: peripheral Wishbone port bundle.
// Master drives strobe/address/data; slave returns ack and read data.
interface wbs_rgb_pwm_if;
  logic       wb_stb;
  logic       wb_we;
  logic [3:0] wb_adr;
  logic [7:0] wb_dat_c;
  logic [7:0] wb_dat;
  logic       wb_ack;

  modport master (
    output wb_stb, wb_we, wb_adr, wb_dat_c,
    input  wb_dat, wb_ack
  );

  modport slave (
    input  wb_stb, wb_we, wb_adr, wb_dat_c,
    output wb_dat, wb_ack
  );
endinterface

// File: rtl/wbs_rgb_pwm.sv
// wbs_rgb_pwm: Wishbone RGB LED PWM with optional per-channel fading.
// Define RGB_FADE_EN to build the FADE bit, STEP register and fade counter.
module wbs_rgb_pwm #(
  parameter logic [7:0] PRESCALE_RST = 8'd0
) (
  input  logic         clk,
  input  logic         rst,
  wbs_rgb_pwm_if.slave wb,
  output logic         led_r,
  output logic         led_g,
  output logic         led_b
);

  logic       en_q, en_d;
  logic       fade_q, fade_d;
  logic       inv_q, inv_d;
  logic [7:0] tgt_r_q, tgt_r_d;
  logic [7:0] tgt_g_q, tgt_g_d;
  logic [7:0] tgt_b_q, tgt_b_d;
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] step_q, step_d;
  logic [7:0] pre_q, pre_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] fc_q, fc_d;
  logic [7:0] cur_r_q, cur_r_d;
  logic [7:0] cur_g_q, cur_g_d;
  logic [7:0] cur_b_q, cur_b_d;
  logic       wrap_q, wrap_d;
  logic       ack_q, ack_d;
  logic [7:0] dat_q, dat_d;
  logic       led_r_q, led_r_d;
  logic       led_g_q, led_g_d;
  logic       led_b_q, led_b_d;

  logic       wr;
  logic       pre_wr;
  logic       step_wr;
  logic       tick;
  logic       wrap;
  logic       busy;
  logic [7:0] rdata;

  function automatic logic [7:0] toward(
    input logic [7:0] cur,
    input logic [7:0] tgt
  );
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  assign wr      = wb.wb_stb && wb.wb_we;
  assign pre_wr  = wr && (wb.wb_adr == 4'h4);
  assign step_wr = wr && (wb.wb_adr == 4'h5);
  assign tick    = en_q && (pre_q == prescale_q);
  assign wrap    = tick && (cnt_q == 8'd254);
  assign busy    = (cur_r_q != tgt_r_q)
                || (cur_g_q != tgt_g_q)
                || (cur_b_q != tgt_b_q);

  // Register file writes
  always_comb begin
    en_d       = en_q;
    fade_d     = fade_q;
    inv_d      = inv_q;
    tgt_r_d    = tgt_r_q;
    tgt_g_d    = tgt_g_q;
    tgt_b_d    = tgt_b_q;
    prescale_d = prescale_q;
    step_d     = step_q;
    if (wr) begin
      unique case (1'b1)
        (wb.wb_adr == 4'h0): begin
          en_d  = wb.wb_dat_c[0];
          inv_d = wb.wb_dat_c[2];
`ifdef RGB_FADE_EN
          fade_d = wb.wb_dat_c[1];
`endif
        end
        (wb.wb_adr == 4'h1): tgt_r_d = wb.wb_dat_c;
        (wb.wb_adr == 4'h2): tgt_g_d = wb.wb_dat_c;
        (wb.wb_adr == 4'h3): tgt_b_d = wb.wb_dat_c;
        (wb.wb_adr == 4'h4): prescale_d = wb.wb_dat_c;
`ifdef RGB_FADE_EN
        (wb.wb_adr == 4'h5): step_d = wb.wb_dat_c;
`endif
        default: ;
      endcase
    end
  end

  // Prescaler, period counter and wrap-aligned duty update
  always_comb begin
    pre_d   = pre_q + 8'd1;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    cur_r_d = cur_r_q;
    cur_g_d = cur_g_q;
    cur_b_d = cur_b_q;
    if (!en_q || tick || pre_wr) pre_d = 8'd0;
    if (!en_q) begin
      cnt_d = 8'd0;
      fc_d  = 8'd0;
    end else if (tick) begin
      cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
    end
    if (wrap) begin
      if (!fade_q) begin
        fc_d    = 8'd0;
        cur_r_d = tgt_r_q;
        cur_g_d = tgt_g_q;
        cur_b_d = tgt_b_q;
      end else if (fc_q == step_q) begin
        fc_d    = 8'd0;
        cur_r_d = toward(cur_r_q, tgt_r_q);
        cur_g_d = toward(cur_g_q, tgt_g_q);
        cur_b_d = toward(cur_b_q, tgt_b_q);
      end else begin
        fc_d = fc_q + 8'd1;
      end
    end
    if (step_wr) fc_d = 8'd0;
  end

  always_comb begin
    rdata = 8'd0;
    unique case (1'b1)
      (wb.wb_adr == 4'h0): rdata = {5'd0, inv_q, fade_q, en_q};
      (wb.wb_adr == 4'h1): rdata = tgt_r_q;
      (wb.wb_adr == 4'h2): rdata = tgt_g_q;
      (wb.wb_adr == 4'h3): rdata = tgt_b_q;
      (wb.wb_adr == 4'h4): rdata = prescale_q;
      (wb.wb_adr == 4'h5): rdata = step_q;
      (wb.wb_adr == 4'h6): rdata = {6'd0, wrap_q, busy};
      (wb.wb_adr == 4'h7): rdata = cur_r_q;
      (wb.wb_adr == 4'h8): rdata = cur_g_q;
      (wb.wb_adr == 4'h9): rdata = cur_b_q;
      default:             rdata = 8'd0;
    endcase
  end

  always_comb begin
    wrap_d  = wrap;
    ack_d   = wb.wb_stb;
    dat_d   = (wb.wb_stb && !wb.wb_we) ? rdata : 8'd0;
    led_r_d = inv_q;
    led_g_d = inv_q;
    led_b_d = inv_q;
    if (en_q) begin
      led_r_d = (cnt_q < cur_r_q) ^ inv_q;
      led_g_d = (cnt_q < cur_g_q) ^ inv_q;
      led_b_d = (cnt_q < cur_b_q) ^ inv_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q       <= 1'b0;
      fade_q     <= 1'b0;
      inv_q      <= 1'b0;
      tgt_r_q    <= 8'd0;
      tgt_g_q    <= 8'd0;
      tgt_b_q    <= 8'd0;
      prescale_q <= PRESCALE_RST;
      step_q     <= 8'd0;
      pre_q      <= 8'd0;
      cnt_q      <= 8'd0;
      fc_q       <= 8'd0;
      cur_r_q    <= 8'd0;
      cur_g_q    <= 8'd0;
      cur_b_q    <= 8'd0;
      wrap_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 8'd0;
      led_r_q    <= 1'b0;
      led_g_q    <= 1'b0;
      led_b_q    <= 1'b0;
    end else begin
      en_q       <= en_d;
      fade_q     <= fade_d;
      inv_q      <= inv_d;
      tgt_r_q    <= tgt_r_d;
      tgt_g_q    <= tgt_g_d;
      tgt_b_q    <= tgt_b_d;
      prescale_q <= prescale_d;
      step_q     <= step_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      fc_q       <= fc_d;
      cur_r_q    <= cur_r_d;
      cur_g_q    <= cur_g_d;
      cur_b_q    <= cur_b_d;
      wrap_q     <= wrap_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      led_r_q    <= led_r_d;
      led_g_q    <= led_g_d;
      led_b_q    <= led_b_d;
    end
  end

  assign wb.wb_ack = ack_q;
  assign wb.wb_dat = dat_q;
  assign led_r     = led_r_q;
  assign led_g     = led_g_q;
  assign led_b     = led_b_q;

endmodule
